// File: rtl/dmem_pkg.sv
// Shared types, funct3 codes and access-decode helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte lanes touched by an access of the given size at the given byte offset.
  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] lane);
    logic [3:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << lane;
      F3_H, F3_HU: be = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Stores only support signed-size codes; loads also accept the unsigned ones.
  function automatic logic f3_legal(input logic [2:0] funct3, input logic wren);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~wren;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords must sit on even addresses, words on multiples of four.
  function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = lane[0];
      2'b10:   mis = |lane;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering between the word-wide RAM and the right-aligned request/response data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the RAM word.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (lane)
      2'd0:    byte_s = rword[7:0];
      2'd1:    byte_s = rword[15:8];
      2'd2:    byte_s = rword[23:16];
      2'd3:    byte_s = rword[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane[1]) begin
      half_s = rword[31:16];
    end else begin
      half_s = rword[15:0];
    end
  end

  // Sign- or zero-extend the selected field into the load result.
  always_comb begin
    rdata_ext = 32'h0000_0000;
    case (funct3)
      F3_B:    rdata_ext = {{24{byte_s[7]}}, byte_s};
      F3_BU:   rdata_ext = {24'h00_0000, byte_s};
      F3_H:    rdata_ext = {{16{half_s[15]}}, half_s};
      F3_HU:   rdata_ext = {16'h0000, half_s};
      F3_W:    rdata_ext = rword;
      default: rdata_ext = 32'h0000_0000;
    endcase
  end

  // Replicate store data across all lanes so the byte enables alone pick the target.
  always_comb begin
    be = byte_en(funct3, lane);
    case (funct3[1:0])
      2'b00:   wdata_rep = {4{wdata[7:0]}};
      2'b01:   wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory bus slave: one request at a time, programmable wait, byte/half/word RAM access.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_wren,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_vld,
  input  logic        i_rsp_rdy,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_r;
  logic [3:0]  wait_cnt_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        wren_r;
  logic [2:0]  funct3_r;
  logic [31:0] rd_word_r;
  logic        req_rdy_r;
  logic        rsp_vld_r;
  logic        rsp_err_r;
  logic [31:0] rsp_rdata_r;
  logic [31:0] mem_r [DEPTH_WORDS];

  logic [32:0]   offset_s;
  logic          in_win_s;
  logic [AW-1:0] idx_s;
  logic          err_s;
  logic          wr_en_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_rep_s;
  logic [31:0]   rdata_ext_s;

  // Decode the latched request: the window test uses a 33-bit difference so addresses
  // below the base borrow out instead of wrapping into the window.
  always_comb begin
    offset_s = {1'b0, addr_r} - {1'b0, BASE_ADDR};
    in_win_s = ~offset_s[32] & (offset_s < WIN_BYTES);
    idx_s    = offset_s[AW+1:2];
    err_s    = ~in_win_s | ~f3_legal(funct3_r, wren_r) | f3_misaligned(funct3_r, addr_r[1:0]);
    wr_en_s  = (state_r == ACCESS) & wren_r & ~err_s;
  end

  dmem_lane_align u_align (
    .funct3    (funct3_r),
    .lane      (addr_r[1:0]),
    .wdata     (wdata_r),
    .rword     (rd_word_r),
    .be        (be_s),
    .wdata_rep (wdata_rep_s),
    .rdata_ext (rdata_ext_s)
  );

  // RAM port: byte-enabled write and synchronous word read, both only in ACCESS.
  always_ff @(posedge i_clk) begin
    if (wr_en_s && be_s[0]) mem_r[idx_s][7:0]   <= wdata_rep_s[7:0];
    if (wr_en_s && be_s[1]) mem_r[idx_s][15:8]  <= wdata_rep_s[15:8];
    if (wr_en_s && be_s[2]) mem_r[idx_s][23:16] <= wdata_rep_s[23:16];
    if (wr_en_s && be_s[3]) mem_r[idx_s][31:24] <= wdata_rep_s[31:24];
    if (state_r == ACCESS) rd_word_r <= mem_r[idx_s];
  end

  // Transaction sequencer with registered handshake and response outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r     <= IDLE;
      wait_cnt_r  <= 4'd0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      wren_r      <= 1'b0;
      funct3_r    <= 3'b000;
      req_rdy_r   <= 1'b1;
      rsp_vld_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_req_vld && req_rdy_r) begin
            addr_r     <= i_req_addr;
            wdata_r    <= i_req_wdata;
            wren_r     <= i_req_wren;
            funct3_r   <= i_req_funct3;
            req_rdy_r  <= 1'b0;
            wait_cnt_r <= 4'd0;
            state_r    <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt_r == WAIT_LAST) begin
            wait_cnt_r <= 4'd0;
            state_r    <= ACCESS;
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        ACCESS: begin
          state_r <= RESP;
        end
        RESP: begin
          // First RESP cycle formats the read word; afterwards hold until accepted.
          if (!rsp_vld_r) begin
            rsp_vld_r   <= 1'b1;
            rsp_err_r   <= err_s;
            rsp_rdata_r <= (err_s || wren_r) ? 32'h0000_0000 : rdata_ext_s;
          end else if (i_rsp_rdy) begin
            rsp_vld_r   <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            req_rdy_r   <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          req_rdy_r <= 1'b1;
          rsp_vld_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_rdy   = req_rdy_r;
  assign o_rsp_vld   = rsp_vld_r;
  assign o_rsp_rdata = rsp_rdata_r;
  assign o_rsp_err   = rsp_err_r;

endmodule
